// File: rtl/gate_send_ceu_pkg.sv
// Shared route-word layout, capability entry type and send-gate FSM states.
// Used by the send gate and by the capability table it owns.
package lynxTypes;

  localparam int ROUTE_BITS     = 14;
  localparam int ROUTE_UL_LSB   = 6;
  localparam int ROUTE_UL_MSB   = 9;
  localparam int ROUTE_SEQ_LSB  = 2;
  localparam int ROUTE_SEQ_MSB  = 5;
  localparam int ROUTE_PORT_MSB = 1;
  localparam int CAP_GRANT_BIT  = 13;

  typedef struct packed {
    logic       valid;
    logic [3:0] ul;
  } cap_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SEND  = 2'd2,
    DENY  = 2'd3
  } gate_state_e;

  // Reserved bits [13:10] are always zero.
  function automatic logic [ROUTE_BITS-1:0] route_pack(input logic [3:0] ul,
                                                       input logic [3:0] seq,
                                                       input logic [1:0] port);
    return {4'b0000, ul, seq, port};
  endfunction

endpackage

// File: rtl/gate_send_ceu_cap_table.sv
// Per-destination capability register file: one host write port, one
// combinational read port. Out-of-range destinations never hit.
module gate_cap_table
  import lynxTypes::*;
#(
  parameter int N_DESTS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_dest,
  input  cap_entry_t wr_entry,
  input  logic [1:0] rd_dest,
  output logic       rd_hit,
  output cap_entry_t rd_entry
);

  cap_entry_t table_q [N_DESTS];
  cap_entry_t table_d [N_DESTS];

  always_comb begin
    table_d = table_q;
    if (wr_en) begin
      for (int unsigned i = 0; i < N_DESTS; i++) begin
        if (wr_dest == 2'(i)) table_d[i] = wr_entry;
      end
    end
  end

  // Reads come straight from the registers, so a same-cycle write is not visible.
  always_comb begin
    rd_hit   = 1'b0;
    rd_entry = '0;
    for (int unsigned i = 0; i < N_DESTS; i++) begin
      if (rd_dest == 2'(i)) begin
        rd_hit   = 1'b1;
        rd_entry = table_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_DESTS; i++) table_q[i] <= '0;
    end else begin
      table_q <= table_d;
    end
  end

endmodule

// File: rtl/gate_send_ceu.sv
// Send-side capability gate: checks each outgoing request against the host
// programmed table and emits a route word on grant, or a deny pulse otherwise.
module gate_send_ceu
  import lynxTypes::*;
#(
  parameter int N_DESTS    = 4,
  parameter int ROUTE_BITS = 14,
  parameter int UL_ID_BITS = 4,
  parameter int CNT_BITS   = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  host_cap_valid,
  input  logic [ROUTE_BITS-1:0] host_cap_in,
  input  logic                  send_req_valid,
  output logic                  send_req_ready,
  input  logic [UL_ID_BITS-1:0] send_req_ul_id,
  input  logic [1:0]            send_req_dest,
  output logic                  route_out_valid,
  input  logic                  route_out_ready,
  output logic [ROUTE_BITS-1:0] route_out,
  output logic                  deny_valid,
  output logic [CNT_BITS-1:0]   deny_count
);

  gate_state_e   state_q, state_d;
  logic          run_q;
  logic [3:0]    ul_q, ul_d;
  logic [1:0]    dest_q, dest_d;
  logic [13:0]   route_q, route_d;
  logic [3:0]    seq_q [N_DESTS];
  logic [3:0]    seq_d [N_DESTS];
  logic [3:0]    seq_rd;
  logic [CNT_BITS-1:0] deny_cnt_q, deny_cnt_d;

  cap_entry_t    wr_entry;
  cap_entry_t    rd_entry;
  logic          rd_hit;
  logic          unused_host_bits;

  assign wr_entry.valid   = host_cap_in[CAP_GRANT_BIT];
  assign wr_entry.ul      = host_cap_in[ROUTE_UL_MSB:ROUTE_UL_LSB];
  assign unused_host_bits = ^{host_cap_in[12:10], host_cap_in[ROUTE_SEQ_MSB:ROUTE_SEQ_LSB]};

  gate_cap_table #(
    .N_DESTS (N_DESTS)
  ) u_cap_table (
    .clk      (aclk),
    .rst_n    (aresetn),
    .wr_en    (host_cap_valid),
    .wr_dest  (host_cap_in[ROUTE_PORT_MSB:0]),
    .wr_entry (wr_entry),
    .rd_dest  (dest_q),
    .rd_hit   (rd_hit),
    .rd_entry (rd_entry)
  );

  always_comb begin
    seq_rd = '0;
    for (int unsigned i = 0; i < N_DESTS; i++) begin
      if (dest_q == 2'(i)) seq_rd = seq_q[i];
    end
  end

  // run_q holds ready low until the first clock edge after reset release.
  assign send_req_ready  = (state_q == IDLE) && run_q;
  assign route_out_valid = (state_q == SEND);
  assign deny_valid      = (state_q == DENY);
  assign route_out       = ROUTE_BITS'(route_q);
  assign deny_count      = deny_cnt_q;

  always_comb begin
    state_d    = state_q;
    ul_d       = ul_q;
    dest_d     = dest_q;
    route_d    = route_q;
    seq_d      = seq_q;
    deny_cnt_d = deny_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (send_req_valid && send_req_ready) begin
          ul_d    = 4'(send_req_ul_id);
          dest_d  = send_req_dest;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (rd_hit && rd_entry.valid && (rd_entry.ul == ul_q)) begin
          route_d = route_pack(ul_q, seq_rd, dest_q);
          state_d = SEND;
        end else begin
          state_d = DENY;
        end
      end
      SEND: begin
        if (route_out_ready) begin
          for (int unsigned i = 0; i < N_DESTS; i++) begin
            if (dest_q == 2'(i)) seq_d[i] = seq_q[i] + 4'd1;
          end
          state_d = IDLE;
        end
      end
      DENY: begin
        if (deny_cnt_q != '1) deny_cnt_d = deny_cnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      ul_q       <= '0;
      dest_q     <= '0;
      route_q    <= '0;
      deny_cnt_q <= '0;
      for (int unsigned i = 0; i < N_DESTS; i++) seq_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      ul_q       <= ul_d;
      dest_q     <= dest_d;
      route_q    <= route_d;
      deny_cnt_q <= deny_cnt_d;
      seq_q      <= seq_d;
    end
  end

endmodule

// File: tb/tb_gate_send_ceu.sv
// Scoreboard bench for gate_send_ceu: a 4-destination and a 2-destination
// instance share stimulus; each has its own expectation queue and monitor.
module tb_gate_send_ceu;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        host_cap_valid = 1'b0;
  logic [13:0] host_cap_in = '0;
  logic        send_req_valid = 1'b0;
  logic [3:0]  send_req_ul_id = '0;
  logic [1:0]  send_req_dest = '0;
  logic        route_out_ready = 1'b1;

  logic        rdy1, rv1, dv1, rdy2, rv2, dv2;
  logic [13:0] ro1, ro2;
  logic [15:0] dc1, dc2;

  int checks = 0;
  int errors = 0;
  logic [14:0] q1[$];
  logic [14:0] q2[$];
  logic [14:0] e1, e2;

  localparam logic [14:0] EDENY = 15'h4000;

  always #5 aclk = ~aclk;

  gate_send_ceu #(.N_DESTS(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .host_cap_valid(host_cap_valid), .host_cap_in(host_cap_in),
    .send_req_valid(send_req_valid), .send_req_ready(rdy1),
    .send_req_ul_id(send_req_ul_id), .send_req_dest(send_req_dest),
    .route_out_valid(rv1), .route_out_ready(route_out_ready), .route_out(ro1),
    .deny_valid(dv1), .deny_count(dc1)
  );

  gate_send_ceu #(.N_DESTS(2)) dut2 (
    .aclk(aclk), .aresetn(aresetn),
    .host_cap_valid(host_cap_valid), .host_cap_in(host_cap_in),
    .send_req_valid(send_req_valid), .send_req_ready(rdy2),
    .send_req_ul_id(send_req_ul_id), .send_req_dest(send_req_dest),
    .route_out_valid(rv2), .route_out_ready(route_out_ready), .route_out(ro2),
    .deny_valid(dv2), .deny_count(dc2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (rv1 && route_out_ready) begin
      if (q1.size() == 0) check("d1_unexpected_route", 32'({1'b0, ro1}), 32'h7fff);
      else begin
        e1 = q1.pop_front();
        check("d1_route", 32'({1'b0, ro1}), 32'(e1));
      end
    end
    if (dv1) begin
      if (q1.size() == 0) check("d1_unexpected_deny", 32'(EDENY), 32'h7fff);
      else begin
        e1 = q1.pop_front();
        check("d1_deny", 32'(EDENY), 32'(e1));
      end
    end
    if (rv2 && route_out_ready) begin
      if (q2.size() == 0) check("d2_unexpected_route", 32'({1'b0, ro2}), 32'h7fff);
      else begin
        e2 = q2.pop_front();
        check("d2_route", 32'({1'b0, ro2}), 32'(e2));
      end
    end
    if (dv2) begin
      if (q2.size() == 0) check("d2_unexpected_deny", 32'(EDENY), 32'h7fff);
      else begin
        e2 = q2.pop_front();
        check("d2_deny", 32'(EDENY), 32'(e2));
      end
    end
  end

  // All tasks below are entered and left at posedge + 1.
  task automatic host_write(input logic [13:0] v);
    host_cap_valid = 1'b1;
    host_cap_in    = v;
    @(posedge aclk); #1;
    host_cap_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] ul, input logic [1:0] dest,
                      input logic [14:0] exp1, input logic [14:0] exp2);
    int n = 0;
    q1.push_back(exp1);
    q2.push_back(exp2);
    send_req_ul_id = ul;
    send_req_dest  = dest;
    send_req_valid = 1'b1;
    @(negedge aclk);
    while (!(rdy1 && rdy2) && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 32'(n), 32'd0);
    @(posedge aclk); #1;
    send_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge aclk);
    while (!(rdy1 && rdy2) && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 32'(n), 32'd0);
    @(posedge aclk); #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge aclk);
    while (!rv1 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 100) check("valid_timeout", 32'(n), 32'd0);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    q1.delete();
    q2.delete();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [13:0] w;
    #1;
    check("rst_ready",      32'(rdy1), 32'd0);
    check("rst_valid",      32'(rv1),  32'd0);
    check("rst_route",      32'(ro1),  32'd0);
    check("rst_deny_valid", 32'(dv1),  32'd0);
    check("rst_deny_count", 32'(dc1),  32'd0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;

    // Grant ul 5 on dest 1; two sends, latency observed on the first.
    host_write(14'h2141);
    send(4'd5, 2'd1, 15'h0141, 15'h0141);
    @(negedge aclk);
    check("lat_check_cycle", 32'(rv1), 32'd0);
    @(negedge aclk);
    check("lat_send_cycle", 32'(rv1), 32'd1);
    @(posedge aclk); #1;
    send(4'd5, 2'd1, 15'h0145, 15'h0145);
    wait_idle();

    // Wrong ul id.
    send(4'd6, 2'd1, EDENY, EDENY);
    wait_idle();
    check("deny_count_1", 32'(dc1), 32'd1);

    // Empty table after reset.
    do_reset();
    check("rst2_deny_count", 32'(dc1), 32'd0);
    send(4'd5, 2'd1, EDENY, EDENY);
    wait_idle();
    check("empty_table_deny", 32'(dc1), 32'd1);

    // Backpressure: word held, no new request accepted.
    host_write(14'h2141);
    route_out_ready = 1'b0;
    send(4'd5, 2'd1, 15'h0141, 15'h0141);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("hold_route", 32'(ro1), 32'h0141);
      check("hold_valid", 32'(rv1), 32'd1);
      check("hold_ready", 32'(rdy1), 32'd0);
    end
    @(posedge aclk); #1;
    route_out_ready = 1'b1;
    wait_idle();

    // Revoke, then revoke while a word is committed in SEND.
    host_write(14'h0001);
    send(4'd5, 2'd1, EDENY, EDENY);
    wait_idle();
    host_write(14'h2141);
    route_out_ready = 1'b0;
    send(4'd5, 2'd1, 15'h0145, 15'h0145);
    wait_valid();
    @(posedge aclk); #1;
    host_write(14'h0001);
    route_out_ready = 1'b1;
    wait_idle();
    send(4'd5, 2'd1, EDENY, EDENY);
    wait_idle();
    check("deny_count_3", 32'(dc1), 32'd3);

    // Sequence wrap on dest 0.
    host_write(14'h20C0);
    for (int k = 0; k < 17; k++) begin
      w = 14'h00C0 | {8'b0, 4'(k % 16), 2'b00};
      send(4'd3, 2'd0, {1'b0, w}, {1'b0, w});
    end
    wait_idle();

    // Reset while in SEND.
    route_out_ready = 1'b0;
    send(4'd3, 2'd0, 15'h00C4, 15'h00C4);
    wait_valid();
    @(posedge aclk); #1;
    aresetn = 1'b0;
    #1;
    check("mid_rst_valid",  32'(rv1), 32'd0);
    check("mid_rst_valid2", 32'(rv2), 32'd0);
    check("mid_rst_route",  32'(ro1), 32'd0);
    q1.delete();
    q2.delete();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    route_out_ready = 1'b1;
    @(posedge aclk); #1;
    check("post_rst_count", 32'(dc1), 32'd0);
    send(4'd3, 2'd0, EDENY, EDENY);
    wait_idle();
    host_write(14'h20C0);
    send(4'd3, 2'd0, 15'h00C0, 15'h00C0);
    wait_idle();

    // Dest 2 exists only on the 4-entry instance.
    host_write(14'h2182);
    send(4'd6, 2'd2, 15'h0182, EDENY);
    wait_idle();
    check("d1_count_dest2", 32'(dc1), 32'd1);
    check("d2_count_dest2", 32'(dc2), 32'd2);
    host_write(14'h2181);
    send(4'd6, 2'd1, 15'h0181, 15'h0181);
    wait_idle();

    @(negedge aclk);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_send_ceu.md
Name: gate_send_ceu

Overview:
Send-side capability gate, the transmit counterpart of the receive-side route check.
- Accepts outgoing send requests (sender UL id, destination port) from user logic.
- Checks each request against a host-programmed per-destination capability table.
- A granted request produces a 14-bit route word: sender UL id in [9:6], per-destination sequence in [5:2], destination port in [1:0]. This is the word the receive gate consumes as its route input.
- A request that fails the check is dropped and counted.

Parameters:
- N_DESTS, 4, number of destination ports / table entries (1..4; port field is 2 bits).
- ROUTE_BITS, 14, route word width.
- UL_ID_BITS, 4, sender UL id width.
- CNT_BITS, 16, deny counter width.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- host_cap_valid  in  1  one-cycle capability write strobe
- host_cap_in  in  14  [13]=1 grant / 0 revoke, [9:6] granted UL id, [1:0] destination port
- send_req_valid  in  1  request valid
- send_req_ready  out  1  request ready
- send_req_ul_id  in  4  requesting UL id
- send_req_dest  in  2  destination port
- route_out_valid  out  1  route word valid
- route_out_ready  in  1  downstream ready
- route_out  out  14  route word
- deny_valid  out  1  one-cycle pulse per denied request
- deny_count  out  16  saturating count of denied requests

Behaviour:
- Reset (async assert, sync-released internally by aclk edge):
  - Outputs: route_out_valid=0, route_out=0, deny_valid=0, deny_count=0, send_req_ready=0 while aresetn low.
  - Table: all entries invalid, ul id 0.
  - All sequence counters 0. FSM goes to IDLE.
- Capability table (sub-module):
  - On host_cap_valid with host_cap_in[1:0] < N_DESTS, entry[dest] is written at the next edge: valid=[13], ul=[9:6].
  - Writes with dest >= N_DESTS are ignored.
  - A write and a read of the same entry in the same cycle: the read sees the old value.
- FSM states: IDLE, CHECK, SEND, DENY.
- IDLE:
  - send_req_ready=1.
  - On valid&ready, capture ul id and dest, then go to CHECK.
- CHECK (1 cycle): grant iff dest < N_DESTS, entry[dest].valid=1, and entry[dest].ul == captured ul.
  - Grant: register route_out = {4'b0, ul, seq[dest], dest}, then go to SEND.
  - Otherwise: go to DENY.
- SEND:
  - route_out_valid=1; route_out is held stable until route_out_ready.
  - On the handshake: seq[dest] increments (mod 16, 15 wraps to 0), route_out_valid drops, FSM returns to IDLE.
- DENY:
  - deny_valid=1 for exactly one cycle.
  - deny_count increments, saturating at 0xFFFF.
  - FSM returns to IDLE.
- Latency and throughput:
  - Accept edge E0; route_out_valid high in the cycle after E1 (2 cycles).
  - At most one request every 3 cycles.
- Commitment: a revoke arriving while in CHECK after the decision edge, or while in SEND, does not cancel the committed word; it affects the next request only.
- send_req_ready is low in CHECK, SEND and DENY; there is no request buffering.
- Reset mid-operation: any in-flight word is discarded and route_out_valid falls immediately on aresetn low.
- Reserved route bits [13:10] are always 0.

Decomposition:
- Add to the lynxTypes package:
  - ROUTE_BITS=14, ROUTE_UL_LSB=6, ROUTE_UL_MSB=9, ROUTE_SEQ_LSB=2, ROUTE_SEQ_MSB=5, ROUTE_PORT_MSB=1, CAP_GRANT_BIT=13.
  - Typedef cap_entry_t {logic valid; logic [3:0] ul;}.
  - Enum for the FSM states.
- One sub-module, gate_cap_table: an N_DESTS-entry register file with one host write port and one combinational read port. The receive gate can later reuse it.

Test Plan:
- Reset, then host_cap_in=0x2141 (grant ul 5, dest 1); request ul 5 dest 1 -> route_out=0x0141 valid 2 cycles after accept; second request -> 0x0145.
- Table as above, request ul 6 dest 1 -> deny_valid pulse, deny_count=1, route_out_valid stays 0; after reset with an empty table, any request -> deny.
- Grant as above, route_out_ready held low 5 cycles -> route_out stable at 0x0141, send_req_ready=0 throughout; accept on the 6th cycle.
- Revoke with host_cap_in=0x0001, then request ul 5 dest 1 -> deny; revoke issued during SEND -> the pending word is still delivered.
- Grant ul 3 to dest 0 (0x20C0), 17 sends -> seq field 0..15 then 0 (17th word 0x00C0); host write to dest 2 with N_DESTS=2 -> ignored, request to dest 2 denied.
- Assert aresetn low while in SEND -> route_out_valid=0 immediately; after release, the table is empty, seq=0, and deny_count=0.
